// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit counter width: ceil(log2(w)), enough to count 0..w-1.
  function automatic int cnt_width(input int w);
    int r;
    r = 32'sd0;
    while ((32'sd1 << r) < w) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_add_fsm.sv
// Sequencer for the serial adder: state register, bit counter,
// busy/done flags and detection of the final (MSB) bit.
module serial_add_fsm
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic load,
  output logic run,
  output logic last,
  output logic busy,
  output logic done
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t        state_r;
  state_t        state_s;
  logic [CW-1:0] cnt_r;
  logic          busy_r;
  logic          done_r;

  assign load = (state_r == ST_IDLE) && start;
  assign run  = (state_r == ST_RUN);
  assign last = run && (cnt_r == LAST_CNT);
  assign busy = busy_r;
  assign done = done_r;

  // Next-state decode; any unexpected encoding falls back to IDLE.
  always_comb begin
    state_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_RUN;
        else       state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (last) state_s = ST_DONE;
        else      state_s = ST_RUN;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register with flags registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
      done_r  <= (state_s == ST_DONE);
    end
  end

  // Bit counter: zeroed on an accepted start, advances once per RUN edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= '0;
    end else if (run) begin
      cnt_r <= cnt_r + CW'(32'd1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder top: one full-adder slice walked LSB-first over WIDTH bits.
// Define SERIAL_ADD_SUB_EN to add the op_sub port (a-b via ~b and carry-in 1).
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             op_sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic             load_s;
  logic             run_s;
  logic             last_s;
  logic [WIDTH-1:0] b_load_s;
  logic             cin0_s;
  logic             fa_sum_s;
  logic             fa_cout_s;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             cout_r;
  logic             ovf_r;

  serial_add_fsm #(
    .WIDTH (WIDTH)
  ) u_fsm (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .load  (load_s),
    .run   (run_s),
    .last  (last_s),
    .busy  (busy),
    .done  (done)
  );

`ifdef SERIAL_ADD_SUB_EN
  assign b_load_s = op_sub ? ~b : b;
  assign cin0_s   = op_sub;
`else
  assign b_load_s = b;
  assign cin0_s   = 1'b0;
`endif

  assign fa_sum_s  = a_sr_r[0] ^ b_sr_r[0] ^ carry_r;
  assign fa_cout_s = (a_sr_r[0] & b_sr_r[0]) | (carry_r & (a_sr_r[0] ^ b_sr_r[0]));

  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

  // Datapath: capture on start, shift one bit per RUN edge, flags on the MSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sr_r  <= '0;
      b_sr_r  <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (load_s) begin
      a_sr_r  <= a;
      b_sr_r  <= b_load_s;
      sum_r   <= '0;
      carry_r <= cin0_s;
    end else if (run_s) begin
      a_sr_r  <= {1'b0, a_sr_r[WIDTH-1:1]};
      b_sr_r  <= {1'b0, b_sr_r[WIDTH-1:1]};
      sum_r   <= {fa_sum_s, sum_r[WIDTH-1:1]};
      carry_r <= fa_cout_s;
      if (last_s) begin
        // carry_r still holds the carry into the MSB on this edge
        cout_r <= fa_cout_s;
        ovf_r  <= carry_r ^ fa_cout_s;
      end else begin
        cout_r <= cout_r;
        ovf_r  <= ovf_r;
      end
    end else begin
      a_sr_r  <= a_sr_r;
      b_sr_r  <= b_sr_r;
      sum_r   <= sum_r;
      carry_r <= carry_r;
    end
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder controller. It sequences a single one-bit full-adder cell over a WIDTH-bit operand pair, one bit per clock, LSB first. It uses a start/busy/done handshake and registered results. It sits between the switch/button front end and the LED display, replacing a parallel ripple chain with one shared full-adder slice.

Parameters:
WIDTH, 4, operand and sum width in bits; legal range 2..16

Ports:
clk  input  1  system clock; all logic is rising-edge
reset  input  1  synchronous active-high reset
start  input  1  request a new operation; sampled only in IDLE
a  input  WIDTH  operand A; captured on the accepted start edge
b  input  WIDTH  operand B; captured on the accepted start edge
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse; high only in DONE
sum  output  WIDTH  result; holds its value until the next accepted start
cout  output  1  carry out of the MSB
ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- States:
  - IDLE=0: busy=0, done=0.
  - RUN=1: busy=1, done=0.
  - DONE=2: busy=1, done=1.
  - Encoding 3 is illegal and goes to IDLE on the next edge.
- Reset: on an edge with reset=1, state=IDLE. sum, cout, ovf, operand shift registers, carry register and bit counter are all cleared to 0. Reset has priority over every other event, including mid-RUN; a partial result is discarded.
- IDLE with start=1 at edge E0:
  - Shift registers load a and b.
  - Carry register loads cin0 (0 by default).
  - Counter loads 0; sum register clears to 0.
  - State goes to RUN.
- RUN, each edge:
  - The full-adder cell takes the shift-register LSBs plus the carry register.
  - The sum bit shifts into sum at the MSB; sum shifts right.
  - Operand registers shift right; the carry register takes the cell's cout.
  - The counter increments.
  - On the edge where counter==WIDTH-1, the pre-edge carry is latched as the carry into the MSB. cout takes the cell's carry, ovf takes the XOR of the two carries, and state goes to DONE.
- DONE: lasts exactly one cycle, then IDLE unconditionally.
- Timing:
  - The last RUN edge is E0+WIDTH; done is high between E0+WIDTH and E0+WIDTH+1.
  - start-to-done latency is WIDTH cycles.
  - Minimum issue interval is WIDTH+2 cycles.
- start in RUN or DONE is ignored and not queued. start held high continuously restarts on the first IDLE edge.
- a and b may change freely after the accepted start edge without affecting the result.
- Arithmetic: modulo 2^WIDTH; cout is the unsigned carry.
- sum, cout and ovf hold their values through IDLE, and through RUN until overwritten at completion. During RUN, sum shows intermediate shifted bits; the bench checks sum only when done=1 or in IDLE.

Optional Feature:
SERIAL_ADD_SUB_EN
- Defined:
  - Adds input port op_sub (1 bit), captured with the operands on the accepted start edge.
  - op_sub=1: the cell sees ~b bits and cin0=1, so sum = a-b mod 2^WIDTH.
  - cout=1 means no borrow (a>=b unsigned); ovf is signed overflow of the subtraction.
- Undefined: op_sub port is absent, cin0 is tied to 0, and the block is add-only.

Decomposition:
- Package serial_add_pkg:
  - State encoding constants ST_IDLE, ST_RUN, ST_DONE (2 bits).
  - Function for the counter width, clog2(WIDTH).
- Sub-module serial_add_fsm:
  - Contains the state register, bit counter, busy/done generation and last-bit detect.
  - Top level holds the operand/sum shift registers, the carry register and the one-bit full-adder cell.

Test Plan:
- WIDTH=4, reset 2 cycles, start with a=3, b=5 -> done pulses exactly 4 cycles after the start edge; sum=8, cout=0, ovf=1; busy low the cycle after done.
- a=15, b=1 -> sum=0, cout=1, ovf=0; sum still reads 0 ten cycles later in IDLE.
- start a=2, b=2; pulse start again with a=7, b=7 at RUN cycle 2 -> the second start is ignored; sum=4; exactly one done pulse.
- start a=6, b=5; assert reset on RUN cycle 2 -> next cycle state IDLE, busy=0, sum=0, cout=0, no done; a following start a=1, b=1 gives sum=2.
- start held high continuously, a=1, b=2 -> done pulses every 6 cycles, sum=3 each time.
- With SERIAL_ADD_SUB_EN:
  - op_sub=1, a=5, b=3 -> sum=2, cout=1.
  - op_sub=1, a=3, b=5 -> sum=14, cout=0.
  - op_sub=1, a=8, b=1 -> sum=7, ovf=1.
